// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
//   User-input side of the digital clock. Debounces the mode/inc/dec buttons,
//   runs the RUN -> SET_HR -> SET_MIN edit FSM, writes the edited time back
//   into the time counter with a one-cycle load strobe, and feeds the display
//   path with values and blink masks so the field being edited flashes.
//
//   Ports
//     clk_100MHz  in   system clock (sole clock)
//     reset       in   synchronous, active-high
//     btn_mode    in   raw mode button (async, bouncing)
//     btn_inc     in   raw increment button (async, bouncing)
//     btn_dec     in   raw decrement button (async, bouncing)
//     cur_hr      in   [5:0] running hours from the time counter
//     cur_min     in   [5:0] running minutes from the time counter
//     load_en     out  one-cycle load strobe to the time counter
//     load_hr     out  [5:0] hours to load (0..23), held after the strobe
//     load_min    out  [5:0] minutes to load (0..59), held after the strobe
//     set_active  out  high in SET_HR / SET_MIN
//     disp_hr     out  [5:0] hours for the display path
//     disp_min    out  [5:0] minutes for the display path
//     blank_hr    out  blank the hour digits
//     blank_min   out  blank the minute digits
// -----------------------------------------------------------------------------

// Per-button conditioning: 2-flop synchronizer, level debounce and a
// registered one-cycle press pulse on an accepted 0->1 flip.
module time_set_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk_100MHz,
   input  logic reset,
   input  logic btn_raw_i,
   output logic press_o
);
   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          stable_q;
   logic          press_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         press_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q <= btn_raw_i;
         sync2_q <= sync1_q;
         press_q <= 1'b0;
         if (sync2_q == stable_q) begin
            // any return to the accepted level restarts the hold window
            cnt_q <= '0;
         end else if (cnt_q == CNT_MAX) begin
            stable_q <= sync2_q;
            cnt_q    <= '0;
            // only the rising flip is an event; releases are silent
            press_q  <= sync2_q;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign press_o = press_q;
endmodule

module time_set_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned BLINK_CYCLES    = 25_000_000
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  logic [5:0] cur_hr,
   input  logic [5:0] cur_min,
   output logic       load_en,
   output logic [5:0] load_hr,
   output logic [5:0] load_min,
   output logic       set_active,
   output logic [5:0] disp_hr,
   output logic [5:0] disp_min,
   output logic       blank_hr,
   output logic       blank_min
);
   localparam int unsigned NUM_BTN = 3;
   localparam int unsigned BW      = $clog2(BLINK_CYCLES);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);
   localparam logic [5:0] HR_MAX  = 6'd23;
   localparam logic [5:0] MIN_MAX = 6'd59;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_SET_HR  = 2'd1,
      ST_SET_MIN = 2'd2
   } state_e;

   // ---------------------------------------------------------------- buttons
   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] press;

   assign btn_raw = {btn_dec, btn_inc, btn_mode};

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      time_set_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_db (
         .clk_100MHz (clk_100MHz),
         .reset      (reset),
         .btn_raw_i  (btn_raw[g]),
         .press_o    (press[g])
      );
   end

   logic ev_mode, ev_inc, ev_dec;
   logic step_inc, step_dec;

   assign ev_mode = press[0];
   assign ev_inc  = press[1];
   assign ev_dec  = press[2];
   // inc+dec together cancel; mode beats both
   assign step_inc = ev_inc & ~ev_dec & ~ev_mode;
   assign step_dec = ev_dec & ~ev_inc & ~ev_mode;

   // ---------------------------------------------------------------- FSM
   state_e        state_q, state_d;
   logic [5:0]    edit_hr_q, edit_hr_d;
   logic [5:0]    edit_min_q, edit_min_d;
   logic          load_en_q, load_en_d;
   logic [5:0]    load_hr_q, load_hr_d;
   logic [5:0]    load_min_q, load_min_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_phase_q, blink_phase_d;

   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         state_q       <= ST_RUN;
         edit_hr_q     <= '0;
         edit_min_q    <= '0;
         load_en_q     <= 1'b0;
         load_hr_q     <= '0;
         load_min_q    <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         edit_hr_q     <= edit_hr_d;
         edit_min_q    <= edit_min_d;
         load_en_q     <= load_en_d;
         load_hr_q     <= load_hr_d;
         load_min_q    <= load_min_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      edit_hr_d     = edit_hr_q;
      edit_min_d    = edit_min_q;
      load_en_d     = 1'b0;
      load_hr_d     = load_hr_q;
      load_min_d    = load_min_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;

      case (state_q)
         ST_RUN: begin
            if (ev_mode) begin
               state_d = ST_SET_HR;
               // out-of-range counter values start the edit from zero
               edit_hr_d  = (cur_hr  > HR_MAX)  ? 6'd0 : cur_hr;
               edit_min_d = (cur_min > MIN_MAX) ? 6'd0 : cur_min;
            end
         end
         ST_SET_HR: begin
            if (ev_mode) begin
               state_d = ST_SET_MIN;
            end else if (step_inc) begin
               edit_hr_d = (edit_hr_q == HR_MAX) ? 6'd0 : edit_hr_q + 6'd1;
            end else if (step_dec) begin
               edit_hr_d = (edit_hr_q == 6'd0) ? HR_MAX : edit_hr_q - 6'd1;
            end
         end
         ST_SET_MIN: begin
            if (ev_mode) begin
               state_d    = ST_RUN;
               load_en_d  = 1'b1;
               load_hr_d  = edit_hr_q;
               load_min_d = edit_min_q;
            end else if (step_inc) begin
               edit_min_d = (edit_min_q == MIN_MAX) ? 6'd0 : edit_min_q + 6'd1;
            end else if (step_dec) begin
               edit_min_d = (edit_min_q == 6'd0) ? MIN_MAX : edit_min_q - 6'd1;
            end
         end
         default: state_d = ST_RUN;
      endcase

      // Blink timer: restarts visible on any state change or edit so the
      // user always sees the field right after touching a button.
      if ((state_d != state_q) || (state_q == ST_RUN)) begin
         blink_cnt_d   = '0;
         blink_phase_d = 1'b1;
      end else if (ev_inc | ev_dec) begin
         blink_cnt_d   = '0;
         blink_phase_d = 1'b1;
      end else if (blink_cnt_q == BLINK_MAX) begin
         blink_cnt_d   = '0;
         blink_phase_d = ~blink_phase_q;
      end else begin
         blink_cnt_d = blink_cnt_q + BW'(1);
      end
   end

   // ---------------------------------------------------------------- outputs
   assign load_en    = load_en_q;
   assign load_hr    = load_hr_q;
   assign load_min   = load_min_q;
   assign set_active = (state_q != ST_RUN);
   assign disp_hr    = set_active ? edit_hr_q  : cur_hr;
   assign disp_min   = set_active ? edit_min_q : cur_min;
   assign blank_hr   = (state_q == ST_SET_HR)  & ~blink_phase_q;
   assign blank_min  = (state_q == ST_SET_MIN) & ~blink_phase_q;
endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- User-input side of the digital clock. Debounces three pushbuttons and runs a set-mode FSM that edits hours and minutes.
- Writes the edited time back into the time counter through a one-cycle load strobe. This is the writer for the counter, whose values the 7-segment path reads.
- Supplies display values and blink masks so the field being edited flashes on the 7-segment display.
- Runs in the 100 MHz domain, between the board buttons and the clock counter / display path.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive cycles a synchronized button level must hold before it is accepted (10 ms at 100 MHz); minimum 2.
- BLINK_CYCLES, 25_000_000, cycles per blink half-period while in a set state (4 Hz toggle); minimum 2.

Ports:
- clk_100MHz  in  1  system clock, sole clock.
- reset  in  1  synchronous, active-high reset.
- btn_mode  in  1  raw mode button, asynchronous, bouncing.
- btn_inc  in  1  raw increment button, asynchronous, bouncing.
- btn_dec  in  1  raw decrement button, asynchronous, bouncing.
- cur_hr  in  6  running hours from the time counter.
- cur_min  in  6  running minutes from the time counter.
- load_en  out  1  one-cycle strobe: the counter loads load_hr/load_min and zeroes seconds.
- load_hr  out  6  hours to load, 0..23.
- load_min  out  6  minutes to load, 0..59.
- set_active  out  1  high while in SET_HR or SET_MIN.
- disp_hr  out  6  hours for the display path.
- disp_min  out  6  minutes for the display path.
- blank_hr  out  1  display path blanks the hour digits while this is high.
- blank_min  out  1  display path blanks the minute digits while this is high.

Behaviour:
- Reset (clk_100MHz edge with reset=1): takes priority over everything.
  - state=RUN; all synchronizer flops, debounce counters and stable levels = 0.
  - edit_hr=edit_min=0; load_en=0; load_hr=load_min=0.
  - blink counter = 0; blink_phase = 1.
  - Reset mid-edit discards the edit; no load_en is issued.
- Input conditioning, per button:
  - 2-flop synchronizer.
  - Debounce counter: cleared whenever the synchronized level equals the stable level; otherwise increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable level flips and the counter clears.
  - A press event is a registered one-cycle pulse on a stable 0->1 flip. Releases produce no event.
  - A glitch shorter than DEBOUNCE_CYCLES produces no event.
  - Latency: raw rise to press pulse = DEBOUNCE_CYCLES+2 edges. The edit register changes on the following edge.
- FSM states: RUN, SET_HR, SET_MIN.
  - RUN, on mode event -> SET_HR. Capture edit_hr=cur_hr (0 if cur_hr>23) and edit_min=cur_min (0 if cur_min>59). inc/dec events are ignored in RUN.
  - SET_HR:
    - inc: edit_hr+1, wraps 23->0.
    - dec: edit_hr-1, wraps 0->23.
    - mode -> SET_MIN.
  - SET_MIN:
    - inc: edit_min+1, wraps 59->0.
    - dec: edit_min-1, wraps 0->59.
    - mode -> RUN, with load_en=1 for exactly one cycle (the cycle after the mode event). load_hr=edit_hr and load_min=edit_min are valid in that cycle and held afterwards.
- Simultaneous events:
  - inc and dec in the same cycle: no change.
  - mode together with inc or dec: mode wins and the value is not modified.
- Display outputs:
  - RUN: disp_hr=cur_hr, disp_min=cur_min, blank_hr=blank_min=0, set_active=0.
  - Set states: disp_hr=edit_hr, disp_min=edit_min, set_active=1.
  - blank_hr = (state==SET_HR) & ~blink_phase; blank_min = (state==SET_MIN) & ~blink_phase.
- Blink:
  - Counter runs only in set states and is cleared in RUN.
  - blink_phase toggles when the counter reaches BLINK_CYCLES-1, then the counter clears.
  - On every state transition the counter clears and blink_phase=1, so a newly selected field is visible immediately.
  - Any inc/dec event also clears the counter and sets blink_phase=1.
- Widths: all arithmetic is 6-bit. Wrap compares are explicit, with no reliance on modulo-64 overflow.

Test Plan:
- Common bench settings: DEBOUNCE_CYCLES=4, BLINK_CYCLES=8.
- Reset scenario: hold reset 3 cycles -> all outputs 0, set_active=0. Then cur_hr=13, cur_min=45 -> disp_hr=13, disp_min=45 with no button activity.
- Debounce scenario:
  - btn_inc pulses of 1, 2 and 3 cycles in SET_HR -> edit_hr unchanged.
  - btn_mode held high -> exactly one event, SET_HR entered 7 edges after the raw rise.
  - 5 bounce toggles then steady high -> exactly one event.
- Full-edit scenario: cur_hr=23, cur_min=59; mode; inc (hr->0); mode; inc (min->0); dec (min->59); mode -> one-cycle load_en with load_hr=0, load_min=59, then set_active=0.
- Wrap/clamp scenario:
  - dec at edit_hr=0 -> 23.
  - cur_hr=30 captured -> edit_hr=0.
  - inc+dec in the same cycle -> no change.
  - mode+inc in the same cycle in SET_HR -> SET_MIN with edit_hr unchanged.
- Blink scenario:
  - In SET_HR, blank_hr toggles every 8 cycles and blank_min stays 0.
  - An inc event forces blank_hr=0 on the next cycle.
  - Entering SET_MIN forces blank_min=0 first.
- Reset mid-edit scenario: in SET_MIN, assert reset for 1 cycle -> state=RUN, load_en never asserted, edit values = 0.
